// File: rtl/decoder_scan.sv
// Registered one-hot channel decoder with direct-select and auto-scan modes.
// Optional build macro DECODER_SCAN_ACTIVE_LOW_EN drives o one-cold (idle value all-ones).
module decoder_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [SEL_W-1:0]        last_ch,
    output logic [(1<<SEL_W)-1:0]   o,
    output logic [SEL_W-1:0]        cur,
    output logic                    wrap
);
    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL - 1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic               wrap_q, wrap_d;
    logic [N-1:0]       o_q, o_d;
    logic               on_d;
    logic [N-1:0]       onehot;
    logic [1:0]         rst_sync_q;
    logic               rst_int_n;

    // Reset asserts asynchronously but releases two edges later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        cur_d   = '0;
        on_d    = 1'b0;
        if (en_n) begin
            state_d = IDLE;
            idx_d   = '0;
            dwell_d = '0;
        end else if (!mode) begin
            state_d = DIRECT;
            idx_d   = '0;
            dwell_d = '0;
            cur_d   = sel;
            on_d    = 1'b1;
        end else begin
            state_d = SCAN;
            on_d    = 1'b1;
            if (state_q != SCAN) begin
                idx_d   = '0;
                dwell_d = '0;
            end else if (dwell_q == DWELL_MAX) begin
                dwell_d = '0;
                // A shrunken last_ch below idx also wraps here.
                if (idx_q >= last_ch) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
            cur_d = idx_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_dec
        assign onehot[gi] = (cur_d == SEL_W'(gi));
    end

    always_comb begin
        o_d = on_d ? onehot : '0;
        if (ACT_LOW) begin
            o_d = ~o_d;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            cur_q   <= '0;
            wrap_q  <= 1'b0;
            o_q     <= {N{ACT_LOW}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            cur_q   <= cur_d;
            wrap_q  <= wrap_d;
            o_q     <= o_d;
        end
    end

    assign o    = o_q;
    assign cur  = cur_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: vector table, hand sequences, a DWELL=1 walk and a random run against a model.
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_n = 1'b1, mode = 1'b0;
    logic [1:0] sel = '0, last_ch = 2'd3;
    logic [3:0] o;
    logic [1:0] cur;
    logic       wrap;
    logic       en8_n = 1'b1, mode8 = 1'b0;
    logic [2:0] sel8 = '0, last8 = 3'd7;
    logic [7:0] o8;
    logic [2:0] cur8;
    logic       wrap8;

    int total = 0;
    int bad = 0;

    // model state: channel currently shown and how many cycles it has been shown
    bit m_on = 0, m_scan = 0, m_wrap = 0;
    int m_cur = 0, m_held = 0;

    decoder_scan #(.SEL_W(2), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel),
        .last_ch(last_ch), .o(o), .cur(cur), .wrap(wrap));

    decoder_scan #(.SEL_W(3), .DWELL(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .en_n(en8_n), .mode(mode8), .sel(sel8),
        .last_ch(last8), .o(o8), .cur(cur8), .wrap(wrap8));

    always #5 clk = ~clk;

    function automatic logic [3:0] pol4(input logic [3:0] x);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic logic [7:0] pol8(input logic [7:0] x);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_scan = 0; m_wrap = 0; m_cur = 0; m_held = 0;
    endtask

    task automatic model_step();
        m_wrap = 0;
        if (en_n) begin
            model_reset();
        end else if (!mode) begin
            m_on = 1; m_scan = 0; m_cur = int'(sel);
        end else if (!m_scan) begin
            m_on = 1; m_scan = 1; m_cur = 0; m_held = 1;
        end else if (m_held == 4) begin
            m_held = 1;
            if (m_cur >= int'(last_ch)) begin
                m_cur = 0; m_wrap = 1;
            end else begin
                m_cur = m_cur + 1;
            end
        end else begin
            m_held = m_held + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic       en_n;
        logic       mode;
        logic [1:0] sel;
        logic [1:0] last;
        logic [3:0] o;
        logic [1:0] cur;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic m, input int s, input int l,
                                input int ch, input bit on, input bit w);
        vec_t v;
        v.en_n = e; v.mode = m; v.sel = 2'(s); v.last = 2'(l);
        v.o = on ? 4'(1 << ch) : 4'b0000;
        v.cur = on ? 2'(ch) : 2'd0;
        v.wrap = w;
        vecs.push_back(v);
    endfunction

    initial begin
        int shrink_ch[21] = '{0,0,0,0,1,1,1,1,2,2,2,2,0,0,0,0,1,1,1,1,0};
        logic [3:0] exp_o;
        logic [3:0] one;

        // reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_o", o, pol4(4'b0000));
        check("rst_o8", o8, pol8(8'h00));
        check("rst_cur", cur, 0);
        check("rst_wrap", wrap, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_o", o, pol4(4'b0000));
        check("idle_cur", cur, 0);

        // vector table
        for (int s = 0; s < 4; s++) add(0, 0, s, 3, s, 1, 0);
        for (int i = 0; i < 20; i++) add(0, 1, 0, 3, (i / 4) % 4, 1, i == 16);
        add(1, 0, 0, 3, 0, 0, 0);
        for (int j = 0; j < 21; j++) add(0, 1, 0, (j < 9) ? 3 : 1, shrink_ch[j], 1, j == 12 || j == 20);
        add(0, 0, 0, 3, 0, 1, 0);
        for (int k = 0; k < 9; k++) add(0, 1, 0, 3, k / 4, 1, 0);
        add(0, 0, 3, 3, 3, 1, 0);
        add(0, 1, 1, 3, 0, 1, 0);
        add(1, 1, 2, 3, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 0, 0, 0, 1, i == 4 || i == 8);
        add(1, 0, 0, 3, 0, 0, 0);

        foreach (vecs[i]) begin
            en_n = vecs[i].en_n; mode = vecs[i].mode;
            sel = vecs[i].sel; last_ch = vecs[i].last;
            tick();
            check($sformatf("vec%0d_o", i), o, pol4(vecs[i].o));
            check($sformatf("vec%0d_cur", i), cur, vecs[i].cur);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wrap);
        end

        // async reset mid-scan clears without a clock edge
        en_n = 0; mode = 1; last_ch = 3;
        repeat (6) tick();
        check("pre_rst_o", o, pol4(4'b0010));
        @(negedge clk);
        rst_n = 1'b0; en_n = 1'b1;
        #1;
        check("async_rst_o", o, pol4(4'b0000));
        check("async_rst_cur", cur, 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_o", o, pol4(4'b0000));

        // DWELL=1, 8 channels walk
        en8_n = 0; mode8 = 1; last8 = 7;
        for (int i = 0; i < 24; i++) begin
            tick();
            one = 4'(i % 8);
            check($sformatf("walk%0d_o", i), o8, pol8(8'(1 << (i % 8))));
            check($sformatf("walk%0d_cur", i), cur8, 3'(one));
            check($sformatf("walk%0d_wrap", i), wrap8, (i % 8 == 0) && (i > 0));
        end
        en8_n = 1;
        tick();
        check("walk_off_o", o8, pol8(8'h00));

        // random run against the model
        for (int i = 0; i < 400; i++) begin
            en_n = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel = 2'($urandom);
            if ($urandom_range(0, 7) == 0) last_ch = 2'($urandom);
            tick();
            exp_o = m_on ? 4'(1 << m_cur) : 4'b0000;
            check("rnd_o", o, pol4(exp_o));
            check("rnd_cur", cur, m_on ? m_cur : 0);
            check("rnd_wrap", wrap, m_wrap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
